fd_fetch_queue: RTL

Small instruction buffer sitting directly downstream of the fetch unit and upstream of the decode stage. Decouples the fetch unit from decode stalls: each accepted fetch record (PC, instruction word, fetch address-error flag, branch-delay flag) is stored and presented to decode in order. Supports a single-cycle flush for branches, `eret` and exception entry. When empty it presents a bubble (NOP, no exception).

---
 rtl/fd_fetch_queue.sv | 104 ++++++++++
 1 files changed

// File: rtl/fd_fetch_queue.sv
// Instruction buffer between fetch and decode: circular queue of fetch records
// presented in order, with single-cycle flush and a bubble when empty.
module fd_fetch_queue #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       f_valid,
    input  logic [31:0]                f_pc,
    input  logic [31:0]                f_instr,
    input  logic                       f_adel,
    input  logic                       f_bd,
    output logic                       f_ready,
    output logic                       d_valid,
    output logic [31:0]                d_pc,
    output logic [31:0]                d_instr,
    output logic [4:0]                 d_exccode,
    output logic                       d_bd,
    input  logic                       d_ready,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic [31:0]   pc_q    [DEPTH];
    logic [31:0]   instr_q [DEPTH];
    logic          adel_q  [DEPTH];
    logic          bd_q    [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;

    logic          enq, deq;

    // Ready/valid depend on registered occupancy only, so a full queue
    // cannot accept in the same cycle decode drains it.
    assign f_ready = (count_q != CNT_FULL);
    assign d_valid = (count_q != '0);
    assign count   = count_q;

    assign enq = f_valid && f_ready && !flush;
    assign deq = d_valid && d_ready && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (deq) rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (enq && !deq)      count_d = count_q + CNT_ONE;
            else if (!enq && deq) count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry payload needs no reset: it is only observable through count_q.
    always_ff @(posedge clk) begin
        if (enq) begin
            pc_q[wr_ptr_q]    <= f_pc;
            instr_q[wr_ptr_q] <= f_instr;
            adel_q[wr_ptr_q]  <= f_adel;
            bd_q[wr_ptr_q]    <= f_bd;
        end
    end

    always_comb begin
        d_pc      = RESET_PC;
        d_instr   = '0;
        d_exccode = '0;
        d_bd      = 1'b0;
        if (d_valid) begin
            d_pc = pc_q[rd_ptr_q];
            d_bd = bd_q[rd_ptr_q];
            if (adel_q[rd_ptr_q]) begin
                d_exccode = 5'd4;
            end else begin
                d_instr = instr_q[rd_ptr_q];
            end
        end
    end

endmodule
